// File: rtl/riscv_alu_arbiter_if.sv
// Request/response bundle between two requesters and riscv_alu_arbiter.
// slave = arbiter side, master = requester side.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_alu_arbiter_if;
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [`XLEN-1:0]  i_req0_a;
  logic [`XLEN-1:0]  i_req0_b;
  logic [3:0]        i_req0_ctrl;
  logic              i_req0_zero_cond;
  logic              o_rsp0_valid;
  logic              i_rsp0_ready;
  logic [`XLEN-1:0]  o_rsp0_result;
  logic              o_rsp0_zero;

  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [`XLEN-1:0]  i_req1_a;
  logic [`XLEN-1:0]  i_req1_b;
  logic [3:0]        i_req1_ctrl;
  logic              i_req1_zero_cond;
  logic              o_rsp1_valid;
  logic              i_rsp1_ready;
  logic [`XLEN-1:0]  o_rsp1_result;
  logic              o_rsp1_zero;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl, i_req0_zero_cond, i_rsp0_ready,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl, i_req1_zero_cond, i_rsp1_ready,
    output o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_zero,
    output o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_zero
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl, i_req0_zero_cond, i_rsp0_ready,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl, i_req1_zero_cond, i_rsp1_ready,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_zero,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_zero
  );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// Shares one riscv_alu between the execute stage (req0, priority) and an aux unit (req1, starvation guard).
// Optional performance counters are enabled with `define RISCV_ALU_ARB_PERF_EN.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_alu_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  riscv_alu_arbiter_if.slave  bus,
  output logic [`XLEN-1:0]    o_alu_a,
  output logic [`XLEN-1:0]    o_alu_b,
  output logic [3:0]          o_alu_ctrl,
  output logic                o_alu_zero_cond,
  input  logic [`XLEN-1:0]    i_alu_result,
  input  logic                i_alu_zero
`ifdef RISCV_ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]    o_perf_grant0,
  output logic [CNT_W-1:0]    o_perf_grant1,
  output logic [CNT_W-1:0]    o_perf_conflict
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic              r_owner;
  logic [3:0]        r_wait_cnt;
  logic [`XLEN-1:0]  r_a;
  logic [`XLEN-1:0]  r_b;
  logic [3:0]        r_ctrl;
  logic              r_zero_cond;
  logic [`XLEN-1:0]  r_result;
  logic              r_zero;

  logic w_rsp_hs;
  logic w_window;
  logic w_win1;
  logic w_rdy0;
  logic w_rdy1;
  logic w_accept;

  // Gating with i_rstn keeps ready low while reset is held, even in IDLE.
  assign w_rsp_hs = (r_state == ST_RESP) && (r_owner ? bus.i_rsp1_ready : bus.i_rsp0_ready);
  assign w_window = i_rstn && ((r_state == ST_IDLE) || w_rsp_hs);
  assign w_win1   = bus.i_req1_valid && (!bus.i_req0_valid || (r_wait_cnt >= LP_LIMIT));
  assign w_rdy1   = w_window && w_win1;
  assign w_rdy0   = w_window && bus.i_req0_valid && !w_win1;
  assign w_accept = w_rdy0 || w_rdy1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= '0;
      r_zero_cond <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_EXEC;
        ST_EXEC: r_state <= ST_RESP;
        ST_RESP: if (w_rsp_hs) r_state <= w_accept ? ST_EXEC : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        r_owner     <= w_rdy1;
        r_a         <= w_rdy1 ? bus.i_req1_a         : bus.i_req0_a;
        r_b         <= w_rdy1 ? bus.i_req1_b         : bus.i_req0_b;
        r_ctrl      <= w_rdy1 ? bus.i_req1_ctrl      : bus.i_req0_ctrl;
        r_zero_cond <= w_rdy1 ? bus.i_req1_zero_cond : bus.i_req0_zero_cond;
      end
      if (r_state == ST_EXEC) begin
        r_result <= i_alu_result;
        r_zero   <= i_alu_zero;
      end
    end
  end

  // Counts consecutive lost conflicts of req1; a withdrawn req1 forfeits its credit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wait_cnt <= 4'd0;
    end else if (!bus.i_req1_valid || w_rdy1) begin
      r_wait_cnt <= 4'd0;
    end else if (w_rdy0 && (r_wait_cnt < LP_LIMIT)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign bus.o_req0_ready  = w_rdy0;
  assign bus.o_req1_ready  = w_rdy1;
  assign bus.o_rsp0_valid  = (r_state == ST_RESP) && !r_owner;
  assign bus.o_rsp1_valid  = (r_state == ST_RESP) && r_owner;
  assign bus.o_rsp0_result = r_result;
  assign bus.o_rsp1_result = r_result;
  assign bus.o_rsp0_zero   = r_zero;
  assign bus.o_rsp1_zero   = r_zero;

  assign o_alu_a         = r_a;
  assign o_alu_b         = r_b;
  assign o_alu_ctrl      = r_ctrl;
  assign o_alu_zero_cond = r_zero_cond;

`ifdef RISCV_ALU_ARB_PERF_EN
  logic [CNT_W-1:0] r_perf_grant0;
  logic [CNT_W-1:0] r_perf_grant1;
  logic [CNT_W-1:0] r_perf_conflict;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_rdy0) r_perf_grant0 <= r_perf_grant0 + CNT_W'(1);
      if (w_rdy1) r_perf_grant1 <= r_perf_grant1 + CNT_W'(1);
      if (w_window && bus.i_req0_valid && bus.i_req1_valid)
        r_perf_conflict <= r_perf_conflict + CNT_W'(1);
    end
  end

  assign o_perf_grant0   = r_perf_grant0;
  assign o_perf_grant1   = r_perf_grant1;
  assign o_perf_conflict = r_perf_conflict;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
